// File: rtl/ft600_pkg.sv
// Shared constants and types for the FT600 receive framer: header and sideband
// field positions, beat geometry and the parser state encoding.
package ft600_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int BEAT_WORDS = 8;
    localparam int LEN_WIDTH  = 12;
    localparam int BEAT_BITS  = DATA_WIDTH * BEAT_WORDS;
    localparam int SB_BITS    = 16;
    localparam int OUT_BITS   = SB_BITS + BEAT_BITS;

    localparam int HDR_TAG_MSB = 15;
    localparam int HDR_TAG_LSB = 12;
    localparam int HDR_LEN_MSB = 11;
    localparam int HDR_LEN_LSB = 0;

    localparam int SB_TAG_LSB   = 12;
    localparam int SB_FIRST     = 11;
    localparam int SB_LAST      = 10;
    localparam int SB_COUNT_LSB = 0;

    typedef enum logic {
        HDR,
        BODY
    } state_t;

    // Bits [9:4] of the sideband are reserved and always zero.
    function automatic logic [SB_BITS-1:0] make_sideband(
        input logic [3:0] tag,
        input logic       first,
        input logic       last,
        input logic [3:0] count
    );
        logic [SB_BITS-1:0] sb;
        sb                     = '0;
        sb[SB_TAG_LSB +: 4]    = tag;
        sb[SB_FIRST]           = first;
        sb[SB_LAST]            = last;
        sb[SB_COUNT_LSB +: 4]  = count;
        return sb;
    endfunction

endpackage

// File: rtl/ft600_rx_framer_if.sv
// Enqueue-style handshake channel: the master raises enq__ENA with enq_v only
// while the slave reports enq__RDY.
interface ft600_rx_framer_if #(
    parameter int WIDTH = 16
);
    logic             enq__ENA;
    logic [WIDTH-1:0] enq_v;
    logic             enq__RDY;

    modport master (output enq__ENA, output enq_v, input enq__RDY);
    modport slave  (input enq__ENA, input enq_v, output enq__RDY);
endinterface

// File: rtl/ft600_beat_reg.sv
// Single-entry valid/data holding register; a load may coincide with a drain,
// in which case the new entry replaces the departing one.
module ft600_beat_reg #(
    parameter int WIDTH = 144
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    assign free = !valid || drain;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ft600_rx_framer.sv
// Parses length-prefixed frames of 16-bit FT600 words and packs the payload
// into 128-bit beats with a 16-bit sideband for a downstream enqueue port.
module ft600_rx_framer
    import ft600_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH,
    parameter int beatWords = BEAT_WORDS,
    parameter int lenWidth  = LEN_WIDTH
) (
    input  logic                CLK,
    input  logic                RST,
    ft600_rx_framer_if.slave    in,
    ft600_rx_framer_if.master   out,
    output logic [15:0]         frameCount
);

    localparam int widxBits = $clog2(beatWords);

    state_t                 state_q;
    state_t                 state_next;
    logic [widxBits-1:0]    widx_q;
    logic [lenWidth-1:0]    remaining_q;
    logic [3:0]             tag_q;
    logic                   first_q;
    logic                   asm_full_q;
    logic [BEAT_BITS-1:0]   asm_data_q;
    logic [SB_BITS-1:0]     asm_sb_q;
    logic [15:0]            frame_count_q;

    logic                   accept;
    logic                   beat_done;
    logic                   word_last;
    logic [BEAT_BITS-1:0]   beat_data;
    logic [SB_BITS-1:0]     beat_sb;
    logic [lenWidth-1:0]    hdr_len;
    logic [3:0]             hdr_tag;

    logic                   out_valid;
    logic [OUT_BITS-1:0]    out_data;
    logic                   out_free;
    logic                   out_drain;
    logic                   out_load;
    logic [OUT_BITS-1:0]    out_load_data;

    assign hdr_len = in.enq_v[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_tag = in.enq_v[HDR_TAG_MSB:HDR_TAG_LSB];

    assign in.enq__RDY = !RST && !asm_full_q;
    assign accept      = in.enq__ENA && in.enq__RDY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= HDR;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        if (accept) begin
            if (state_q == HDR) begin
                if (hdr_len != '0) begin
                    state_next = BODY;
                end
            end else if (remaining_q == lenWidth'(1)) begin
                state_next = HDR;
            end
        end
    end

    // A beat completes on the accepting cycle itself, so it can bypass the
    // assembly register straight into the output stage when that is free.
    always_comb begin
        beat_data = asm_data_q;
        beat_sb   = '0;
        beat_done = 1'b0;
        word_last = 1'b0;
        if (accept) begin
            if (state_q == HDR) begin
                if (hdr_len == '0) begin
                    beat_done = 1'b1;
                    beat_data = '0;
                    beat_sb   = make_sideband(hdr_tag, 1'b1, 1'b1, 4'd0);
                end
            end else begin
                beat_data[widx_q*dataWidth +: dataWidth] = in.enq_v;
                word_last = (remaining_q == lenWidth'(1));
                if (widx_q == widxBits'(beatWords - 1) || word_last) begin
                    beat_done = 1'b1;
                    beat_sb   = make_sideband(tag_q, first_q, word_last,
                                              4'(widx_q) + 4'd1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            widx_q      <= '0;
            remaining_q <= '0;
            tag_q       <= '0;
            first_q     <= 1'b0;
            asm_full_q  <= 1'b0;
            asm_data_q  <= '0;
            asm_sb_q    <= '0;
        end else begin
            if (accept) begin
                if (state_q == HDR) begin
                    tag_q       <= hdr_tag;
                    remaining_q <= hdr_len;
                    widx_q      <= '0;
                    first_q     <= 1'b1;
                end else begin
                    remaining_q <= remaining_q - lenWidth'(1);
                    if (beat_done) begin
                        widx_q  <= '0;
                        first_q <= 1'b0;
                    end else begin
                        widx_q  <= widx_q + widxBits'(1);
                    end
                end
            end
            // Unused words of a short beat must read as zero, so the
            // assembly buffer is cleared whenever a beat leaves it.
            if (beat_done) begin
                if (out_free) begin
                    asm_data_q <= '0;
                end else begin
                    asm_data_q <= beat_data;
                    asm_sb_q   <= beat_sb;
                    asm_full_q <= 1'b1;
                end
            end else if (asm_full_q && out_free) begin
                asm_full_q <= 1'b0;
                asm_data_q <= '0;
            end else if (accept) begin
                asm_data_q <= beat_data;
            end
        end
    end

    assign out_drain     = out_valid && out.enq__RDY && !RST;
    assign out_load      = (beat_done || asm_full_q) && out_free;
    assign out_load_data = asm_full_q ? {asm_sb_q, asm_data_q} : {beat_sb, beat_data};

    ft600_beat_reg #(
        .WIDTH (OUT_BITS)
    ) u_out_reg (
        .clk       (CLK),
        .rst       (RST),
        .load      (out_load),
        .load_data (out_load_data),
        .drain     (out_drain),
        .valid     (out_valid),
        .data      (out_data),
        .free      (out_free)
    );

    assign out.enq__ENA = out_drain;
    assign out.enq_v    = out_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_count_q <= '0;
        end else if (out_drain && out_data[BEAT_BITS + SB_LAST]) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign frameCount = frame_count_q;

endmodule

// File: tb/tb_ft600_rx_framer.sv
// Directed bench for ft600_rx_framer: frame parsing, beat packing, stall
// buffering, mid-frame reset and frame counter wrap.
module tb_ft600_rx_framer;
    import ft600_pkg::*;

    logic        CLK;
    logic        RST;
    logic [15:0] frame_count;

    int checks;
    int errors;
    int ena_count;
    logic capture;
    logic [OUT_BITS-1:0] beats[$];

    ft600_rx_framer_if #(.WIDTH(16))       in_if ();
    ft600_rx_framer_if #(.WIDTH(OUT_BITS)) out_if ();

    ft600_rx_framer dut (
        .CLK        (CLK),
        .RST        (RST),
        .in         (in_if),
        .out        (out_if),
        .frameCount (frame_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Beats are recorded mid-cycle, when the push that lands on the next
    // rising edge is already stable.
    always @(negedge CLK) begin
        if (out_if.enq__ENA) begin
            ena_count <= ena_count + 1;
            if (capture) beats.push_back(out_if.enq_v);
        end
    end

    task automatic checkOutput(input string name, input logic [OUT_BITS-1:0] observed,
                               input logic [OUT_BITS-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", name, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] word);
        int wait_cycles;
        wait_cycles = 0;
        while (!in_if.enq__RDY && wait_cycles < 50) begin
            @(posedge CLK);
            #1;
            wait_cycles++;
        end
        if (!in_if.enq__RDY) begin
            checkOutput("ready_timeout", OUT_BITS'(in_if.enq__RDY), OUT_BITS'(1'b1));
        end else begin
            in_if.enq__ENA = 1'b1;
            in_if.enq_v    = word;
            @(posedge CLK);
            #1;
            in_if.enq__ENA = 1'b0;
            in_if.enq_v    = 16'h0;
        end
    endtask

    function automatic logic [BEAT_BITS-1:0] seqPayload(input logic [15:0] base, input int n);
        logic [BEAT_BITS-1:0] p;
        p = '0;
        for (int k = 0; k < n; k++) p[k*16 +: 16] = base + 16'(k);
        return p;
    endfunction

    initial begin
        int base_idx;
        int ena_before;
        logic rdy_drop;

        checks = 0;
        errors = 0;
        ena_count = 0;
        capture = 1'b0;
        RST = 1'b1;
        in_if.enq__ENA = 1'b0;
        in_if.enq_v = 16'h0;
        out_if.enq__RDY = 1'b1;

        idle(2);
        checkOutput("reset_in_rdy", OUT_BITS'(in_if.enq__RDY), OUT_BITS'(1'b0));
        checkOutput("reset_out_ena", OUT_BITS'(out_if.enq__ENA), OUT_BITS'(1'b0));
        checkOutput("reset_frame_count", OUT_BITS'(frame_count), OUT_BITS'(16'h0000));
        RST = 1'b0;
        #1;
        checkOutput("post_reset_in_rdy", OUT_BITS'(in_if.enq__RDY), OUT_BITS'(1'b1));

        $display("[TB] three-word frame");
        applyStimulus(16'h3003);
        applyStimulus(16'h0001);
        applyStimulus(16'h0002);
        applyStimulus(16'h0003);
        checkOutput("f3_ena", OUT_BITS'(out_if.enq__ENA), OUT_BITS'(1'b1));
        checkOutput("f3_beat", out_if.enq_v, {16'h3C03, 128'h0000_0003_0002_0001});
        idle(1);
        checkOutput("f3_count", OUT_BITS'(frame_count), OUT_BITS'(16'd1));
        checkOutput("f3_idle_ena", OUT_BITS'(out_if.enq__ENA), OUT_BITS'(1'b0));

        $display("[TB] ten-word frame");
        applyStimulus(16'h100A);
        for (int i = 0; i < 8; i++) applyStimulus(16'hA000 + 16'(i));
        checkOutput("f10_beat1", out_if.enq_v, {16'h1808, seqPayload(16'hA000, 8)});
        applyStimulus(16'hA008);
        applyStimulus(16'hA009);
        checkOutput("f10_beat2_ena", OUT_BITS'(out_if.enq__ENA), OUT_BITS'(1'b1));
        checkOutput("f10_beat2", out_if.enq_v, {16'h1402, seqPayload(16'hA008, 2)});
        idle(1);
        checkOutput("f10_count", OUT_BITS'(frame_count), OUT_BITS'(16'd2));

        $display("[TB] zero-length frame");
        applyStimulus(16'h5000);
        checkOutput("f0_beat", out_if.enq_v, {16'h5C00, 128'h0});
        applyStimulus(16'h6001);
        applyStimulus(16'h1234);
        checkOutput("f0_next_hdr", out_if.enq_v, {16'h6C01, 128'h1234});
        idle(1);
        checkOutput("f0_count", OUT_BITS'(frame_count), OUT_BITS'(16'd4));

        $display("[TB] stalled consumer");
        capture = 1'b1;
        base_idx = beats.size();
        out_if.enq__RDY = 1'b0;
        applyStimulus(16'h7011);
        for (int i = 0; i < 15; i++) applyStimulus(16'hC000 + 16'(i));
        checkOutput("stall_rdy_w15", OUT_BITS'(in_if.enq__RDY), OUT_BITS'(1'b1));
        applyStimulus(16'hC00F);
        checkOutput("stall_rdy_w16", OUT_BITS'(in_if.enq__RDY), OUT_BITS'(1'b0));
        idle(3);
        checkOutput("stall_rdy_held", OUT_BITS'(in_if.enq__RDY), OUT_BITS'(1'b0));
        checkOutput("stall_no_push", OUT_BITS'(out_if.enq__ENA), OUT_BITS'(1'b0));
        out_if.enq__RDY = 1'b1;
        applyStimulus(16'hC010);
        idle(2);
        capture = 1'b0;
        checkOutput("stall_beat_total", OUT_BITS'(beats.size() - base_idx), OUT_BITS'(3));
        if (beats.size() - base_idx == 3) begin
            checkOutput("stall_beat1", beats[base_idx],     {16'h7808, seqPayload(16'hC000, 8)});
            checkOutput("stall_beat2", beats[base_idx + 1], {16'h7008, seqPayload(16'hC008, 8)});
            checkOutput("stall_beat3", beats[base_idx + 2], {16'h7401, seqPayload(16'hC010, 1)});
        end
        checkOutput("stall_count", OUT_BITS'(frame_count), OUT_BITS'(16'd5));

        $display("[TB] mid-frame reset");
        applyStimulus(16'h8008);
        for (int i = 0; i < 4; i++) applyStimulus(16'hD000 + 16'(i));
        ena_before = ena_count;
        RST = 1'b1;
        #1;
        checkOutput("midrst_in_rdy", OUT_BITS'(in_if.enq__RDY), OUT_BITS'(1'b0));
        checkOutput("midrst_out_ena", OUT_BITS'(out_if.enq__ENA), OUT_BITS'(1'b0));
        idle(1);
        RST = 1'b0;
        idle(2);
        checkOutput("midrst_no_push", OUT_BITS'(ena_count), OUT_BITS'(ena_before));
        checkOutput("midrst_count_clr", OUT_BITS'(frame_count), OUT_BITS'(16'd0));
        applyStimulus(16'h2001);
        applyStimulus(16'hBEEF);
        checkOutput("midrst_beat", out_if.enq_v, {16'h2C01, 128'hBEEF});
        idle(1);
        checkOutput("midrst_count", OUT_BITS'(frame_count), OUT_BITS'(16'd1));

        $display("[TB] frame counter wrap");
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        #1;
        rdy_drop = 1'b0;
        ena_before = ena_count;
        for (int i = 0; i < 65535; i++) begin
            if (!in_if.enq__RDY) rdy_drop = 1'b1;
            applyStimulus(16'h0000);
        end
        idle(1);
        checkOutput("wrap_count_ffff", OUT_BITS'(frame_count), OUT_BITS'(16'hFFFF));
        if (!in_if.enq__RDY) rdy_drop = 1'b1;
        applyStimulus(16'h0000);
        idle(1);
        checkOutput("wrap_count_zero", OUT_BITS'(frame_count), OUT_BITS'(16'h0000));
        checkOutput("wrap_rdy_steady", OUT_BITS'(rdy_drop), OUT_BITS'(1'b0));
        checkOutput("wrap_push_total", OUT_BITS'(ena_count - ena_before), OUT_BITS'(65536));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
